// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: default datapath widths and the fetch entry layout
// that travels from instruction fetch to instruction decode.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode. It is a circular buffer of
// {pc, instr} entries with a valid/ready handshake on both sides. A flush
// (redirect) empties it in one edge. With BYPASS=1, an entry offered to an
// empty queue is visible on the dequeue side in the same cycle.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN   = ILEN_DEF,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [XLEN-1:0]            enq_pc,
    input  logic [ILEN-1:0]            enq_instr,
    input  logic                       flush,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [ILEN-1:0]            deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    // Entries are held in the package layout. PC and instruction widths up to
    // the package defaults are zero-extended on write and truncated on read.
    fetch_entry_t entry_q [DEPTH];
    fetch_entry_t head_entry;

    logic queue_empty;
    logic bypass_hit;
    logic bypass_taken;
    logic enq_fire;
    logic deq_fire;
    logic push;
    logic pop;

    // enq_ready depends only on the occupancy, never on deq_ready.
    assign queue_empty  = (count_reg == '0);
    assign enq_ready    = (count_reg != CW'(DEPTH));
    assign bypass_hit   = (BYPASS != 0) && queue_empty && enq_valid && !flush;
    assign deq_valid    = (!queue_empty && !flush) || bypass_hit;
    assign enq_fire     = enq_valid && enq_ready && !flush;
    assign deq_fire     = deq_valid && deq_ready && !flush;

    // An entry consumed straight through the bypass is never written, and it
    // never moves the pointers.
    assign bypass_taken = bypass_hit && deq_ready;
    assign push         = enq_fire && !bypass_taken;
    assign pop          = deq_fire && !bypass_hit;

    assign head_entry   = entry_q[rd_ptr_reg];
    assign deq_pc       = bypass_hit ? enq_pc    : XLEN'(head_entry.pc);
    assign deq_instr    = bypass_hit ? enq_instr : ILEN'(head_entry.instr);
    assign count        = count_reg;

    // Next pointer and occupancy values. Flush overrides any fire in the cycle.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One storage slot per entry. A slot is written only when it is the write
    // target of a push. A flush leaves the slot contents stale.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            // Capture the offered entry when this slot is the write target.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= fetch_entry_t'{pc: XLEN_DEF'(enq_pc), instr: ILEN_DEF'(enq_instr)};
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. It runs one BYPASS=0 instance and one BYPASS=1
// instance side by side on the same stimulus. Each instance is compared
// against a queue-based reference model every cycle. A table and a few
// hand-written sequences add explicit expectations.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        flush;
    logic        deq_ready;

    logic        er0, dv0, er1, dv1;
    logic [31:0] pc0, in0, pc1, in1;
    logic [2:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one queue of {pc, instr} per instance.
    logic [63:0] mq [2][$];

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .BYPASS(0)) u_dut0 (
        .i_clk(clk), .i_rstn(i_rstn),
        .enq_valid(enq_valid), .enq_ready(er0), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .flush(flush),
        .deq_valid(dv0), .deq_ready(deq_ready), .deq_pc(pc0), .deq_instr(in0),
        .count(cnt0)
    );

    fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .BYPASS(1)) u_dut1 (
        .i_clk(clk), .i_rstn(i_rstn),
        .enq_valid(enq_valid), .enq_ready(er1), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .flush(flush),
        .deq_valid(dv1), .deq_ready(deq_ready), .deq_pc(pc1), .deq_instr(in1),
        .count(cnt1)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Compare both instances with the model for the current cycle, then
    // advance the model by the edge that follows.
    task automatic model_step();
        for (int b = 0; b < 2; b++) begin
            int          sz;
            logic        byp, edv, acc, con;
            logic [63:0] head;
            sz   = mq[b].size();
            byp  = (b == 1) && (sz == 0) && enq_valid && !flush;
            edv  = !flush && ((sz != 0) || byp);
            chk($sformatf("model%0d_enq_ready", b), 64'(b ? er1 : er0), 64'(sz != DEPTH));
            chk($sformatf("model%0d_deq_valid", b), 64'(b ? dv1 : dv0), 64'(edv));
            chk($sformatf("model%0d_count", b), 64'(b ? cnt1 : cnt0), 64'(sz));
            if (edv) begin
                head = byp ? {enq_pc, enq_instr} : mq[b][0];
                chk($sformatf("model%0d_deq_pc", b), 64'(b ? pc1 : pc0), 64'(head[63:32]));
                chk($sformatf("model%0d_deq_instr", b), 64'(b ? in1 : in0), 64'(head[31:0]));
            end
            if (flush) begin
                mq[b].delete();
            end else begin
                acc = enq_valid && (sz != DEPTH);
                con = edv && deq_ready;
                if (!(byp && con)) begin
                    if (con) void'(mq[b].pop_front());
                    if (acc) mq[b].push_back({enq_pc, enq_instr});
                end
            end
        end
    endtask

    // Drive one cycle's inputs just after the edge, let them settle, and check
    // against the model. The caller may add explicit checks before tick().
    task automatic apply(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = instr_of(pc);
        deq_ready = dr;
        flush     = fl;
        #1;
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset between edges, check the outputs immediately, then release
    // it before the next edge.
    task automatic reset_mid(input string tag);
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        enq_pc = '0; enq_instr = '0;
        #2;
        i_rstn = 1'b0;
        #1;
        chk({tag, "_count0"}, 64'(cnt0), 64'd0);
        chk({tag, "_deq_valid0"}, 64'(dv0), 64'd0);
        chk({tag, "_enq_ready0"}, 64'(er0), 64'd1);
        chk({tag, "_deq_pc0"}, 64'(pc0), 64'd0);
        chk({tag, "_count1"}, 64'(cnt1), 64'd0);
        chk({tag, "_deq_valid1"}, 64'(dv1), 64'd0);
        mq[0].delete();
        mq[1].delete();
        #3;
        i_rstn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        logic        er;
        logic        dv;
        logic [31:0] dpc;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mkv(input logic ev, input logic [31:0] pc, input logic dr,
                                 input logic fl, input logic er, input logic dv,
                                 input logic [31:0] dpc, input logic [2:0] cnt);
        vec_t v;
        v.ev = ev; v.pc = pc; v.dr = dr; v.fl = fl;
        v.er = er; v.dv = dv; v.dpc = dpc; v.cnt = cnt;
        return v;
    endfunction

    vec_t        vt [21];
    logic [31:0] seen [$];

    initial begin
        // Fill, refuse, and drain. The expectations are for the BYPASS=0 instance.
        vt[0]  = mkv(1, 32'h00, 0, 0, 1, 0, 32'h00, 0);
        vt[1]  = mkv(1, 32'h04, 0, 0, 1, 1, 32'h00, 1);
        vt[2]  = mkv(1, 32'h08, 0, 0, 1, 1, 32'h00, 2);
        vt[3]  = mkv(1, 32'h0C, 0, 0, 1, 1, 32'h00, 3);
        vt[4]  = mkv(1, 32'h10, 0, 0, 0, 1, 32'h00, 4);
        vt[5]  = mkv(0, 32'h00, 1, 0, 0, 1, 32'h00, 4);
        vt[6]  = mkv(0, 32'h00, 1, 0, 1, 1, 32'h04, 3);
        vt[7]  = mkv(0, 32'h00, 1, 0, 1, 1, 32'h08, 2);
        vt[8]  = mkv(0, 32'h00, 1, 0, 1, 1, 32'h0C, 1);
        vt[9]  = mkv(0, 32'h00, 0, 0, 1, 0, 32'h00, 0);
        // Flush while enqueueing 0x40 at occupancy 3.
        vt[10] = mkv(1, 32'h20, 0, 0, 1, 0, 32'h00, 0);
        vt[11] = mkv(1, 32'h24, 0, 0, 1, 1, 32'h20, 1);
        vt[12] = mkv(1, 32'h28, 0, 0, 1, 1, 32'h20, 2);
        vt[13] = mkv(1, 32'h40, 0, 1, 1, 0, 32'h00, 3);
        vt[14] = mkv(0, 32'h00, 0, 0, 1, 0, 32'h00, 0);
        // Streaming: one cycle behind the enqueue, occupancy holds at 1.
        vt[15] = mkv(1, 32'h50, 1, 0, 1, 0, 32'h00, 0);
        vt[16] = mkv(1, 32'h54, 1, 0, 1, 1, 32'h50, 1);
        vt[17] = mkv(1, 32'h58, 1, 0, 1, 1, 32'h54, 1);
        vt[18] = mkv(1, 32'h5C, 1, 0, 1, 1, 32'h58, 1);
        vt[19] = mkv(0, 32'h00, 1, 0, 1, 1, 32'h5C, 1);
        vt[20] = mkv(0, 32'h00, 0, 0, 1, 0, 32'h00, 0);

        i_rstn = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        enq_pc = '0; enq_instr = '0;
        #2;
        chk("reset_enq_ready", 64'(er0), 64'd1);
        chk("reset_deq_valid", 64'(dv0), 64'd0);
        chk("reset_deq_pc", 64'(pc0), 64'd0);
        chk("reset_deq_instr", 64'(in0), 64'd0);
        chk("reset_count", 64'(cnt0), 64'd0);
        chk("reset_count_byp", 64'(cnt1), 64'd0);
        #5;
        i_rstn = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            apply(vt[i].ev, vt[i].pc, vt[i].dr, vt[i].fl);
            $display("vec %0d: ev=%0d pc=%h dr=%0d fl=%0d -> er=%0d dv=%0d dpc=%h cnt=%0d",
                     i, vt[i].ev, vt[i].pc, vt[i].dr, vt[i].fl, er0, dv0, pc0, cnt0);
            chk($sformatf("vec%0d_enq_ready", i), 64'(er0), 64'(vt[i].er));
            chk($sformatf("vec%0d_deq_valid", i), 64'(dv0), 64'(vt[i].dv));
            chk($sformatf("vec%0d_count", i), 64'(cnt0), 64'(vt[i].cnt));
            if (vt[i].dv) begin
                chk($sformatf("vec%0d_deq_pc", i), 64'(pc0), 64'(vt[i].dpc));
                chk($sformatf("vec%0d_deq_instr", i), 64'(in0), 64'(instr_of(vt[i].dpc)));
            end
            tick();
        end

        // Wrap-around: occupancy 2, then eight cycles that both enqueue and
        // dequeue, then drain. Ten entries cross the pointer wrap.
        seen.delete();
        for (int k = 0; k < 12; k++) begin
            logic        ev;
            logic        dr;
            logic [31:0] pc;
            ev = (k < 10);
            dr = (k >= 2);
            pc = 32'h200 + 32'(4 * k);
            apply(ev, pc, dr, 1'b0);
            if (dv0 && deq_ready) seen.push_back(pc0);
            tick();
        end
        $display("wrap: %0d entries dequeued", seen.size());
        chk("wrap_count", 64'(seen.size()), 64'd10);
        for (int k = 0; k < 10 && k < seen.size(); k++)
            chk($sformatf("wrap_order%0d", k), 64'(seen[k]), 64'(32'h200 + 32'(4 * k)));

        // Bypass into an empty queue, consumed and then stored.
        reset_mid("clear");
        apply(1'b1, 32'h80, 1'b1, 1'b0);
        $display("bypass consume: dv=%0d pc=%h cnt=%0d", dv1, pc1, cnt1);
        chk("byp_deq_valid", 64'(dv1), 64'd1);
        chk("byp_deq_pc", 64'(pc1), 64'h80);
        chk("byp_count_same", 64'(cnt1), 64'd0);
        chk("nobyp_deq_valid", 64'(dv0), 64'd0);
        tick();
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        chk("byp_count_after", 64'(cnt1), 64'd0);
        tick();
        apply(1'b1, 32'h84, 1'b0, 1'b0);
        $display("bypass store: dv=%0d pc=%h cnt=%0d", dv1, pc1, cnt1);
        chk("byp_hold_deq_pc", 64'(pc1), 64'h84);
        tick();
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        chk("byp_stored_count", 64'(cnt1), 64'd1);
        chk("byp_stored_pc", 64'(pc1), 64'h84);
        tick();

        // Randomised traffic against the model.
        begin
            logic [31:0] next_pc;
            next_pc = 32'h1000;
            for (int n = 0; n < 400; n++) begin
                logic ev, dr, fl;
                ev = ($urandom_range(0, 9) < 7);
                dr = ($urandom_range(0, 9) < 6);
                fl = ($urandom_range(0, 19) == 0);
                apply(ev, next_pc, dr, fl);
                if (ev && !fl) next_pc = next_pc + 32'd4;
                tick();
            end
            $display("random: %0d cycles done", 400);
        end

        // Reset mid-stream at occupancy 2.
        reset_mid("clear2");
        apply(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        apply(1'b1, 32'h304, 1'b0, 1'b0);
        tick();
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_reset_count", 64'(cnt0), 64'd2);
        reset_mid("midrst");
        apply(1'b1, 32'h100, 1'b1, 1'b0);
        tick();
        apply(1'b1, 32'h104, 1'b1, 1'b0);
        $display("after reset: dv=%0d pc=%h", dv0, pc0);
        chk("post_reset_first_valid", 64'(dv0), 64'd1);
        chk("post_reset_first_pc", 64'(pc0), 64'h100);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
